port_allocator: RTL
===================

Name: port_allocator

Overview:
- Output-side allocator for the 3-port router (ports X, Y, LOCAL).
- Each input port presents the destination its routing stage computed. The allocator arbitrates per output port and locks the output to one input for a whole wormhole packet.
- It drives the registered 2-bit select codes for the output data_selector41 muxes and returns per-input grant and abort handshakes.
- It is the responder to the router_algorithm request side: it turns per-input destinations into per-output selects.

Parameters:
- LOCK_TIMEOUT, 64: maximum consecutive granted cycles without a tail flit before the lock is forcibly released; minimum 2.
- TO_W, $clog2(LOCK_TIMEOUT+1): width of the per-output watchdog counter (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_dest_x  in  2  destination of input X: 00 none, 01 out X, 10 out Y, 11 out LOCAL
- req_dest_y  in  2  destination of input Y, same encoding
- req_dest_local  in  2  destination of input LOCAL, same encoding
- req_tail_x / req_tail_y / req_tail_local  in  1 each  current flit of that input is the packet tail
- fail  in  3  output port failed: bit0 X, bit1 Y, bit2 LOCAL
- control_x / control_y / control_local  out  2 each  mux select of that output: 00 none, 01 from in X, 10 from in Y, 11 from in LOCAL
- grant_x / grant_y / grant_local  out  1 each  flit presented by that input this cycle is consumed
- abort_x / abort_y / abort_local  out  1 each  one-cycle pulse: packet of that input was cut off

Behaviour:
- All outputs are registered. On rst at a clock edge: control_*=00, grant_*=0, abort_*=0, all locks clear, watchdog counters 0, round-robin pointers set to "last=LOCAL" (X has first priority).
- Per-output state: IDLE or LOCKED(owner). The grant of input i equals "its destination output is LOCKED to i".
- Input protocol:
  - req_dest is held stable and nonzero from header to tail; there are no bubbles inside a packet.
  - A flit is consumed in every cycle where grant=1.
- IDLE -> LOCKED:
  - At an edge, the output is not failed and one or more inputs request it; inputs already owning another output are excluded.
  - The winner is chosen round-robin in order X, Y, LOCAL, starting after the pointer.
  - From the next cycle: control = owner code, owner grant=1, pointer = winner, counter=0.
  - Latency from request to grant is 1 cycle.
- LOCKED, granted cycle without tail: counter increments and the lock holds.
- LOCKED, granted cycle with tail:
  - At that edge the lock releases.
  - Arbitration among the other requesters of that output happens at the same edge (back-to-back, no idle cycle). If there is none, control=00 and grant=0 next cycle.
  - The finishing input is excluded at that edge.
- fail bit high at an edge:
  - The output goes IDLE, control=00 and no new lock forms while fail is high.
  - If it was LOCKED, the owner's grant drops and abort pulses for one cycle.
  - The pointer is unchanged.
- Watchdog: when the counter reaches LOCK_TIMEOUT-1 on a granted non-tail cycle, the lock releases with control=00, grant=0 and abort pulsing for the owner. There is no re-arbitration at that edge.
- Requests with dest=00 are ignored. A request to a failed output sees grant stay 0 with no abort unless it was mid-packet.
- fail and tail at the same edge: fail wins, abort asserts.
- Outputs never have two owners; each input holds at most one lock.
- rst mid-packet clears everything. Inputs must restart packets.

Decomposition:
- Shared package router_pkg:
  - destination codes DEST_NONE/X/Y/LOCAL (2'b00..11);
  - select codes SEL_NONE/IN_X/IN_Y/IN_LOCAL;
  - port index constants PORT_X=0, PORT_Y=1, PORT_LOCAL=2.
- One sub-module, rr_lock_arbiter, instantiated 3 times, once per output. Each instance holds:
  - the 3-way round-robin pointer;
  - the lock and owner state;
  - the watchdog counter.
- The top level forms request vectors per output from the req_dest_* inputs and ORs the per-output grants and aborts back to the inputs.

Test Plan:
- Single packet: in X dest=10 for 3 flits, tail on the 3rd -> control_y=01 cycles 1-3, grant_x=1 cycles 1-3, control_y=00 and grant_x=0 from cycle 4.
- Contention after reset: X and LOCAL both dest=11, 1-flit packets -> X granted first (control_local=01), then LOCAL back-to-back (control_local=11), then X again.
- Independent outputs: X->Y, Y->X, LOCAL->LOCAL at once -> control_x=10, control_y=01, control_local=11 in the same cycle, all grants 1.
- Fail mid-packet: Y owns out X, fail=001 on the 2nd flit -> control_x=00, grant_y=0, abort_y pulse 1 cycle; no relock while fail=001.
- Watchdog: LOCKED with no tail for LOCAL_TIMEOUT=4 -> release after 4 granted cycles, abort pulse, control 00.
- Reset mid-packet: rst high 1 cycle -> all control 00, grants 0; next arbitration starts with X priority.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: destination and mux-select codes, port indices,
// the per-output lock state type and the 3-way round-robin pick helper.
package router_pkg;

  // Destination codes carried on req_dest_*
  localparam logic [1:0] DEST_NONE  = 2'b00;
  localparam logic [1:0] DEST_X     = 2'b01;
  localparam logic [1:0] DEST_Y     = 2'b10;
  localparam logic [1:0] DEST_LOCAL = 2'b11;

  // Output mux select codes driven on control_*
  localparam logic [1:0] SEL_NONE     = 2'b00;
  localparam logic [1:0] SEL_IN_X     = 2'b01;
  localparam logic [1:0] SEL_IN_Y     = 2'b10;
  localparam logic [1:0] SEL_IN_LOCAL = 2'b11;

  // Port indices (used for inputs and outputs alike)
  localparam int PORT_X     = 0;
  localparam int PORT_Y     = 1;
  localparam int PORT_LOCAL = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Select code for an input index: index 0..2 maps onto 01..11.
  function automatic logic [1:0] sel_of_port(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  // Round-robin pick among req[2:0], searching X, Y, LOCAL starting after 'last'.
  function automatic rr_pick_t rr_pick(input logic [2:0] req, input logic [1:0] last);
    rr_pick_t   res;
    logic [3:0] req_w;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    req_w = {1'b0, req};
    case (last)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (req_w[c0]) begin
      res = '{found: 1'b1, idx: c0};
    end else if (req_w[c1]) begin
      res = '{found: 1'b1, idx: c1};
    end else if (req_w[c2]) begin
      res = '{found: 1'b1, idx: c2};
    end else begin
      res = '{found: 1'b0, idx: 2'd0};
    end
    return res;
  endfunction

endpackage

// File: rtl/port_allocator_if.sv
// Handshake bundle between the three router input stages and the allocator.
//   req_dest_* / req_tail_* / fail : requests toward the allocator
//   control_* / grant_* / abort_*  : registered responses from the allocator
// master = input-stage side, slave = allocator side.
interface port_allocator_if;
  logic [1:0] req_dest_x;
  logic [1:0] req_dest_y;
  logic [1:0] req_dest_local;
  logic       req_tail_x;
  logic       req_tail_y;
  logic       req_tail_local;
  logic [2:0] fail;
  logic [1:0] control_x;
  logic [1:0] control_y;
  logic [1:0] control_local;
  logic       grant_x;
  logic       grant_y;
  logic       grant_local;
  logic       abort_x;
  logic       abort_y;
  logic       abort_local;

  modport master (
    output req_dest_x, req_dest_y, req_dest_local,
    output req_tail_x, req_tail_y, req_tail_local, fail,
    input  control_x, control_y, control_local,
    input  grant_x, grant_y, grant_local,
    input  abort_x, abort_y, abort_local
  );

  modport slave (
    input  req_dest_x, req_dest_y, req_dest_local,
    input  req_tail_x, req_tail_y, req_tail_local, fail,
    output control_x, control_y, control_local,
    output grant_x, grant_y, grant_local,
    output abort_x, abort_y, abort_local
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Per-output arbiter: round-robin pointer, wormhole lock/owner and watchdog.
//   clk, rst   : clock, synchronous active-high reset
//   req_i      : inputs requesting this output (one bit per input, X/Y/LOCAL)
//   tail_i     : per-input tail flag of the current flit
//   fail_i     : this output is failed
//   control_o  : registered mux select code
//   grant_o    : registered one-hot of the owning input
//   abort_o    : registered one-cycle abort pulse toward the cut-off input
module rr_lock_arbiter
  import router_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_i,
  input  logic [2:0] tail_i,
  input  logic       fail_i,
  output logic [1:0] control_o,
  output logic [2:0] grant_o,
  output logic [2:0] abort_o
);

  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  lock_state_e     state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      control_q, control_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      abort_q, abort_d;
  logic [2:0]      owner_oh_s;
  logic            owner_tail_s;
  rr_pick_t        pick_idle_s;
  rr_pick_t        pick_rearb_s;

  // Next-state: lock formation, tail hand-over, fail cut-off and watchdog release.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    abort_d   = 3'b000;
    owner_oh_s   = (state_q == ST_LOCKED) ? (3'b001 << owner_q) : 3'b000;
    owner_tail_s = |(tail_i & owner_oh_s);
    pick_idle_s  = rr_pick(req_i, ptr_q);
    // The finishing owner still shows this destination at its tail edge; keep it out.
    pick_rearb_s = rr_pick(req_i & ~owner_oh_s, ptr_q);
    case (state_q)
      ST_IDLE: begin
        if (fail_i) begin
          state_d = ST_IDLE;
        end else if (pick_idle_s.found) begin
          state_d = ST_LOCKED;
          owner_d = pick_idle_s.idx;
          ptr_d   = pick_idle_s.idx;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (fail_i) begin
          state_d = ST_IDLE;
          abort_d = owner_oh_s;
          cnt_d   = '0;
        end else if (owner_tail_s) begin
          cnt_d = '0;
          if (pick_rearb_s.found) begin
            owner_d = pick_rearb_s.idx;
            ptr_d   = pick_rearb_s.idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          // Watchdog: no re-arbitration on this edge.
          state_d = ST_IDLE;
          abort_d = owner_oh_s;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    control_d = (state_d == ST_LOCKED) ? sel_of_port(owner_d) : SEL_NONE;
    grant_d   = (state_d == ST_LOCKED) ? (3'b001 << owner_d) : 3'b000;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd2;
      cnt_q     <= '0;
      control_q <= SEL_NONE;
      grant_q   <= 3'b000;
      abort_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      control_q <= control_d;
      grant_q   <= grant_d;
      abort_q   <= abort_d;
    end
  end

  assign control_o = control_q;
  assign grant_o   = grant_q;
  assign abort_o   = abort_q;

endmodule

// File: rtl/port_allocator.sv
// Output-side allocator of the 3-port router (X, Y, LOCAL).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of port_allocator_if (requests in, selects/grants/aborts out)
// One rr_lock_arbiter per output; requests are built from req_dest_* and the
// per-output grant/abort one-hots are ORed back onto each input.
module port_allocator
  import router_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  port_allocator_if.slave bus
);

  logic [1:0] dest_s [3];
  logic [2:0] tail_s;
  logic [2:0] owned_s;
  logic [2:0] req_s   [3];
  logic [1:0] ctrl_s  [3];
  logic [2:0] grant_s [3];
  logic [2:0] abort_s [3];

  // Per-output request vectors; an input locked to some other output is excluded.
  always_comb begin
    dest_s[PORT_X]     = bus.req_dest_x;
    dest_s[PORT_Y]     = bus.req_dest_y;
    dest_s[PORT_LOCAL] = bus.req_dest_local;
    tail_s  = {bus.req_tail_local, bus.req_tail_y, bus.req_tail_x};
    owned_s = grant_s[PORT_X] | grant_s[PORT_Y] | grant_s[PORT_LOCAL];
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++) begin
        req_s[o][i] = (dest_s[i] == 2'(o + 1)) && !(owned_s[i] && !grant_s[o][i]);
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_out
    rr_lock_arbiter #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_s[g]),
      .tail_i    (tail_s),
      .fail_i    (bus.fail[g]),
      .control_o (ctrl_s[g]),
      .grant_o   (grant_s[g]),
      .abort_o   (abort_s[g])
    );
  end

  assign bus.control_x     = ctrl_s[PORT_X];
  assign bus.control_y     = ctrl_s[PORT_Y];
  assign bus.control_local = ctrl_s[PORT_LOCAL];

  assign bus.grant_x     = grant_s[PORT_X][PORT_X]     | grant_s[PORT_Y][PORT_X]     | grant_s[PORT_LOCAL][PORT_X];
  assign bus.grant_y     = grant_s[PORT_X][PORT_Y]     | grant_s[PORT_Y][PORT_Y]     | grant_s[PORT_LOCAL][PORT_Y];
  assign bus.grant_local = grant_s[PORT_X][PORT_LOCAL] | grant_s[PORT_Y][PORT_LOCAL] | grant_s[PORT_LOCAL][PORT_LOCAL];

  assign bus.abort_x     = abort_s[PORT_X][PORT_X]     | abort_s[PORT_Y][PORT_X]     | abort_s[PORT_LOCAL][PORT_X];
  assign bus.abort_y     = abort_s[PORT_X][PORT_Y]     | abort_s[PORT_Y][PORT_Y]     | abort_s[PORT_LOCAL][PORT_Y];
  assign bus.abort_local = abort_s[PORT_X][PORT_LOCAL] | abort_s[PORT_Y][PORT_LOCAL] | abort_s[PORT_LOCAL][PORT_LOCAL];

endmodule
